move_executor: RTL
==================

Name: move_executor

Overview:
- Owns the authoritative board state and turn flag, and serves as the consumer end of the move-mask interface.
- Turns player square clicks into a selected piece, which it presents to the move-generation block. After a fixed latency it captures the returned 64-bit possible-moves mask.
- Validates the target click against that mask, then commits the move to the board, including capture, castling rook relocation and pawn promotion.
- Feeds board_out to the move generator and to the display path.

Parameters:
- MASK_LATENCY, 2: wait cycles after sel_figure/sel_position update before possible_moves is sampled. Must be ≥1; the move generator registers its output.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset (rst==0 resets on the clk edge)
- click_valid  in  1  one-cycle strobe: player clicked a square
- click_pos  in  6  clicked square: [5:3] row, [2:0] column; index = row*8+col, row 0 = black home rank
- possible_moves  in  64  move mask returned by the move generator for sel_figure/sel_position
- sel_figure  out  4  figure code presented to the move generator; 0 when nothing is selected
- sel_position  out  6  source square presented to the move generator
- board_out  out  4 per square, [0:7][0:7]  current board
- highlight_mask  out  64  captured mask while a piece is selected, else 0
- turn  out  1  side to move: 0 white, 1 black
- busy  out  1  high in WAIT_MASK and COMMIT
- move_done  out  1  one-cycle pulse when a move is committed
- move_illegal  out  1  one-cycle pulse when a target click is rejected
- sel_error  out  1  one-cycle pulse when a selection click is rejected
- captured  out  4  code of the piece removed by the last move (0 if none); held until the next commit
- game_over  out  1  set when a king is captured; sticky until reset

Behaviour:
- Figure codes:
  - 0 empty
  - White: 1 pawn, 2 bishop, 3 knight, 4 rook, 5 queen, 6 king
  - Black: 7 pawn, 8 bishop, 9 knight, A rook, B queen, C king
  - "Own piece" means 1–6 when turn=0 and 7–C when turn=1.
- Reset values:
  - Row 0: A 9 8 B C 8 9 A
  - Row 1: all 7
  - Rows 2–5: all 0
  - Row 6: all 1
  - Row 7: 4 3 2 5 6 2 3 4
  - All other outputs and state: 0; FSM goes to IDLE.
  - Reset asserted in any state (including mid-WAIT_MASK or COMMIT) restores all of the above on that edge. No partial commit survives.
- All outputs are registered.
- IDLE:
  - sel_figure=0, highlight_mask=0.
  - On click_valid with an own piece at click_pos: latch src=click_pos and fig=board[src], drive sel_figure=fig and sel_position=src, load wait counter, go to WAIT_MASK.
  - On click_valid with an empty or opponent square: pulse sel_error, stay in IDLE.
- WAIT_MASK:
  - Count MASK_LATENCY cycles after sel outputs change.
  - On the final count: mask_reg<=possible_moves, highlight_mask<=possible_moves, go to SELECTED.
  - click_valid is ignored.
- SELECTED, on click_valid:
  - click_pos==src: deselect; sel_figure<=0, highlight_mask<=0, go to IDLE.
  - Own piece at click_pos: reselect; latch the new src/fig and go to WAIT_MASK.
  - mask_reg[click_pos]==1: dst=click_pos, go to COMMIT.
  - Otherwise: pulse move_illegal, stay in SELECTED, mask unchanged.
- COMMIT (exactly 1 cycle):
  - board[src]<=0, board[dst]<=fig, captured<=prior board[dst].
  - Promotion: fig 1 with dst row 0 writes 5; fig 7 with dst row 7 writes B.
  - Castling, also executed in this same cycle:
    - fig 6, src 60→62: board[7][7]<=0, board[7][5]<=4
    - fig 6, src 60→58: board[7][0]<=0, board[7][3]<=4
    - fig C, src 4→6: board[0][7]<=0, board[0][5]<=A
    - fig C, src 4→2: board[0][0]<=0, board[0][3]<=A
  - Pulse move_done on this cycle's output edge. Toggle turn, clear sel_figure and highlight_mask.
  - If the prior board[dst] was 6 or C: set game_over and go to GAME_OVER; otherwise go to IDLE.
- GAME_OVER:
  - All clicks are ignored and no pulses are produced. board_out stays frozen until reset.
- Latency:
  - Click to mask captured: MASK_LATENCY+1 cycles.
  - Valid target click to board update: 2 cycles (SELECTED→COMMIT→register).
- The mask is trusted. No extra legality checks are performed beyond own-piece and mask tests.

Test Plan:
- Reset (rst=0 for 2 cycles): board_out[0][4]=C, [6][4]=1, [7][3]=5, [4][4]=0; turn=0, busy=0, all pulses 0.
- White double push: click 52 → sel_figure=1, sel_position=52. The stub drives possible_moves bits 44 and 36; highlight_mask equals it after MASK_LATENCY+1 cycles. Click 36 → move_done pulses once; board[4][4]=1, board[6][4]=0, turn=1, captured=0.
- Wrong side and empty square with turn=0: click 12 → sel_error pulse; click 35 → sel_error pulse. State stays IDLE and the board is unchanged.
- Illegal target then deselect: select 52 with mask {44,36}. Click 28 → move_illegal pulse, highlight unchanged. Click 52 → highlight_mask=0, sel_figure=0. A click during WAIT_MASK is ignored.
- Castling: with squares 61 and 62 cleared, select 60 with mask bit 62 and click 62 → board[7][6]=6, [7][5]=4, [7][4]=0, [7][7]=0.
- Promotion, king capture and reset:
  - White pawn at 8 moves to 0, where board[0][0] holds an A → board[0][0]=5, captured=A.
  - A move capturing C → game_over=1; subsequent clicks produce no pulses.
  - rst=0 asserted while in WAIT_MASK → initial board restored on that edge.

Source files
------------

// File: rtl/move_executor.sv
// Chess move executor: owns the board and the side to move, selects a piece, samples the
// move generator's mask after a fixed latency and commits target clicks the mask allows.
module move_executor #(
    parameter int MASK_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 click_valid,
    input  logic [5:0]           click_pos,
    input  logic [63:0]          possible_moves,
    output logic [3:0]           sel_figure,
    output logic [5:0]           sel_position,
    output logic [0:7][0:7][3:0] board_out,
    output logic [63:0]          highlight_mask,
    output logic                 turn,
    output logic                 busy,
    output logic                 move_done,
    output logic                 move_illegal,
    output logic                 sel_error,
    output logic [3:0]           captured,
    output logic                 game_over
);
    localparam int CW = (MASK_LATENCY < 2) ? 1 : $clog2(MASK_LATENCY + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(MASK_LATENCY);

    // Row 0 is the black home rank; element [0][0] sits in the top nibble.
    localparam logic [0:7][0:7][3:0] INIT_BOARD = {
        32'hA98BC89A, 32'h77777777, 32'h00000000, 32'h00000000,
        32'h00000000, 32'h00000000, 32'h11111111, 32'h43256234
    };

    typedef enum logic [2:0] {IDLE, WAIT_MASK, SELECTED, COMMIT, GAME_OVER} state_t;

    state_t          state;
    logic [5:0]      src, dst;
    logic [3:0]      fig;
    logic [63:0]     mask_reg;
    logic [CW-1:0]   cnt;

    logic [3:0]      click_fig, dst_prior, put_fig;
    logic            click_own;

    function automatic logic is_own(input logic [3:0] f, input logic t);
        return t ? (f >= 4'd7 && f <= 4'd12) : (f >= 4'd1 && f <= 4'd6);
    endfunction

    assign click_fig = board_out[click_pos[5:3]][click_pos[2:0]];
    assign click_own = is_own(click_fig, turn);
    assign dst_prior = board_out[dst[5:3]][dst[2:0]];

    // Pawns reaching the far rank always become queens.
    always_comb begin
        put_fig = fig;
        if (fig == 4'd1 && dst[5:3] == 3'd0)
            put_fig = 4'd5;
        else if (fig == 4'd7 && dst[5:3] == 3'd7)
            put_fig = 4'hB;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            board_out      <= INIT_BOARD;
            src            <= '0;
            dst            <= '0;
            fig            <= '0;
            mask_reg       <= '0;
            cnt            <= '0;
            sel_figure     <= '0;
            sel_position   <= '0;
            highlight_mask <= '0;
            turn           <= 1'b0;
            busy           <= 1'b0;
            move_done      <= 1'b0;
            move_illegal   <= 1'b0;
            sel_error      <= 1'b0;
            captured       <= '0;
            game_over      <= 1'b0;
        end else begin
            move_done    <= 1'b0;
            move_illegal <= 1'b0;
            sel_error    <= 1'b0;
            case (state)
                IDLE: begin
                    if (click_valid) begin
                        if (click_own) begin
                            src          <= click_pos;
                            fig          <= click_fig;
                            sel_figure   <= click_fig;
                            sel_position <= click_pos;
                            cnt          <= CNT_LOAD;
                            busy         <= 1'b1;
                            state        <= WAIT_MASK;
                        end else begin
                            sel_error <= 1'b1;
                        end
                    end
                end
                WAIT_MASK: begin
                    if (cnt == CW'(1)) begin
                        mask_reg       <= possible_moves;
                        highlight_mask <= possible_moves;
                        busy           <= 1'b0;
                        state          <= SELECTED;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                SELECTED: begin
                    if (click_valid) begin
                        if (click_pos == src) begin
                            sel_figure     <= '0;
                            highlight_mask <= '0;
                            state          <= IDLE;
                        end else if (click_own) begin
                            src            <= click_pos;
                            fig            <= click_fig;
                            sel_figure     <= click_fig;
                            sel_position   <= click_pos;
                            highlight_mask <= '0;
                            cnt            <= CNT_LOAD;
                            busy           <= 1'b1;
                            state          <= WAIT_MASK;
                        end else if (mask_reg[click_pos]) begin
                            dst   <= click_pos;
                            busy  <= 1'b1;
                            state <= COMMIT;
                        end else begin
                            move_illegal <= 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    board_out[src[5:3]][src[2:0]] <= 4'd0;
                    board_out[dst[5:3]][dst[2:0]] <= put_fig;
                    // Castling moves the rook in the same cycle as the king.
                    if (fig == 4'd6 && src == 6'd60 && dst == 6'd62) begin
                        board_out[7][7] <= 4'd0;
                        board_out[7][5] <= 4'd4;
                    end
                    if (fig == 4'd6 && src == 6'd60 && dst == 6'd58) begin
                        board_out[7][0] <= 4'd0;
                        board_out[7][3] <= 4'd4;
                    end
                    if (fig == 4'hC && src == 6'd4 && dst == 6'd6) begin
                        board_out[0][7] <= 4'd0;
                        board_out[0][5] <= 4'hA;
                    end
                    if (fig == 4'hC && src == 6'd4 && dst == 6'd2) begin
                        board_out[0][0] <= 4'd0;
                        board_out[0][3] <= 4'hA;
                    end
                    captured       <= dst_prior;
                    move_done      <= 1'b1;
                    turn           <= ~turn;
                    sel_figure     <= '0;
                    highlight_mask <= '0;
                    busy           <= 1'b0;
                    if (dst_prior == 4'd6 || dst_prior == 4'hC) begin
                        game_over <= 1'b1;
                        state     <= GAME_OVER;
                    end else begin
                        state <= IDLE;
                    end
                end
                GAME_OVER: ;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
